// File: rtl/arch_defs_pkg.sv
// Shared definitions for the execution unit.
//   alu_op_t    : 4-bit operation encoding issued by the control unit
//                 (4'hF is unused and behaves as a NOP)
//   alu_state_t : sequencing states of the ALU front end
//   DATA_WIDTH_DEFAULT : default operand/result width
package arch_defs_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_ADC = 4'h1,
    OP_SUB = 4'h2,
    OP_SBC = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_INR = 4'h7,
    OP_DCR = 4'h8,
    OP_CMP = 4'h9,
    OP_SHL = 4'hA,
    OP_SHR = 4'hB,
    OP_ROL = 4'hC,
    OP_ROR = 4'hD,
    OP_MUL = 4'hE
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mul_serial.sv
// Unsigned shift-add multiplier, one partial product per step.
//   clk, reset : clock, asynchronous active-high reset
//   start      : load operands, clear the accumulator, arm the step counter
//   step       : perform one shift-add step
//   a, b       : multiplicand / multiplier (sampled on start)
//   last       : high during the step that completes the product
//   product    : full 2*DATA_WIDTH product (valid after the last step)
module alu_mul_serial
  import arch_defs_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    step,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    last,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [2*DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [CW-1:0]           cnt;

  // Counter runs DATA_WIDTH-1 .. 0, so the step taken at zero is the final one.
  assign last = step && (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
    end else if (start) begin
      mcand   <= {{DATA_WIDTH{1'b0}}, a};
      mplier  <= b;
      product <= '0;
      cnt     <= CW'(DATA_WIDTH - 1);
    end else if (step) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with Z/N/C flag register and a serial multiplier.
//   clk, reset    : clock, asynchronous active-high reset
//   start         : one-cycle strobe, samples op/a_in/b_in (ignored while busy)
//   op            : operation select
//   a_in, b_in    : operands
//   result        : registered result, held until the next writing op
//   flag_zero/negative/carry : registered flags
//   busy          : MUL in progress (through the MUL_DONE cycle)
//   done          : one-cycle pulse per accepted operation
module alu_seq
  import arch_defs_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  alu_op_t               op,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  flag_zero,
  output logic                  flag_negative,
  output logic                  flag_carry,
  output logic                  busy,
  output logic                  done
);

  localparam int W = DATA_WIDTH;

  alu_state_t state;

  logic [W-1:0]   nxt_res;
  logic [W-1:0]   flag_src;
  logic [W:0]     ext;
  logic           nxt_z, nxt_n, nxt_c;
  logic           upd;
  logic           mul_start, mul_step, mul_last;
  logic [2*W-1:0] mul_prod;

  assign mul_start = (state == IDLE) && start && (op == OP_MUL);
  assign mul_step  = (state == MUL_RUN);

  alu_mul_serial #(.DATA_WIDTH(W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .step    (mul_step),
    .a       (a_in),
    .b       (b_in),
    .last    (mul_last),
    .product (mul_prod)
  );

  // Single-cycle op decode; everything not listed (MUL, unused codes) holds.
  always_comb begin
    ext      = '0;
    nxt_res  = result;
    nxt_c    = flag_carry;
    flag_src = result;
    upd      = 1'b0;
    case (op)
      OP_ADD: begin ext = {1'b0, a_in} + {1'b0, b_in};                    upd = 1'b1; end
      OP_ADC: begin ext = {1'b0, a_in} + {1'b0, b_in} + {{W{1'b0}}, flag_carry}; upd = 1'b1; end
      OP_SUB: begin ext = {1'b0, a_in} - {1'b0, b_in};                    upd = 1'b1; end
      OP_SBC: begin ext = {1'b0, a_in} - {1'b0, b_in} - {{W{1'b0}}, flag_carry}; upd = 1'b1; end
      OP_CMP: begin ext = {1'b0, a_in} - {1'b0, b_in};                    upd = 1'b1; end
      OP_AND: begin ext = {1'b0, a_in & b_in};                            upd = 1'b1; end
      OP_OR:  begin ext = {1'b0, a_in | b_in};                            upd = 1'b1; end
      OP_XOR: begin ext = {1'b0, a_in ^ b_in};                            upd = 1'b1; end
      OP_INR: begin ext = {flag_carry, a_in + 1'b1};                      upd = 1'b1; end
      OP_DCR: begin ext = {flag_carry, a_in - 1'b1};                      upd = 1'b1; end
      OP_SHL: begin ext = {a_in[W-1], a_in << 1};                         upd = 1'b1; end
      OP_SHR: begin ext = {a_in[0], a_in >> 1};                           upd = 1'b1; end
      OP_ROL: begin ext = {a_in[W-1], a_in[W-2:0], flag_carry};           upd = 1'b1; end
      OP_ROR: begin ext = {a_in[0], flag_carry, a_in[W-1:1]};             upd = 1'b1; end
      default: ;
    endcase
    if (upd) begin
      nxt_c    = ext[W];
      flag_src = ext[W-1:0];
      // CMP leaves the result register untouched; its flags come from A-B.
      if (op != OP_CMP) nxt_res = ext[W-1:0];
    end
    nxt_z = (flag_src == '0);
    nxt_n = flag_src[W-1];
    if (!upd) begin
      nxt_z = flag_zero;
      nxt_n = flag_negative;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      result        <= '0;
      flag_zero     <= 1'b0;
      flag_negative <= 1'b0;
      flag_carry    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              busy  <= 1'b1;
              state <= MUL_RUN;
            end else begin
              result        <= nxt_res;
              flag_zero     <= nxt_z;
              flag_negative <= nxt_n;
              flag_carry    <= nxt_c;
              done          <= 1'b1;
            end
          end
        end
        MUL_RUN: begin
          if (mul_last) state <= MUL_DONE;
        end
        MUL_DONE: begin
          result        <= mul_prod[W-1:0];
          flag_zero     <= (mul_prod[W-1:0] == '0);
          flag_negative <= mul_prod[W-1];
          flag_carry    <= |mul_prod[2*W-1:W];
          done          <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
